// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared types and constants for the 16-bit ALU and the
//               stages around it. Defines the result word layout {Z, flags}
//               and the positions of the five flags inside the flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int ALU_DW  = 16;

   // Flag vector layout: {S, ZR, CY, P, V}
   localparam int FLAG_S  = 4;
   localparam int FLAG_ZR = 3;
   localparam int FLAG_CY = 2;
   localparam int FLAG_P  = 1;
   localparam int FLAG_V  = 0;

   typedef logic [4:0] alu_flags_t;

   typedef struct packed {
      logic [ALU_DW-1:0] z;
      alu_flags_t        flags;
   } alu_result_t;

endpackage
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : skid_fifo2
// Description : Two-entry FIFO of alu_result_t. The oldest entry lives in a
//               dedicated head register so the consumer-facing data comes
//               straight from a flop with no read mux; the second entry
//               waits in a tail register.
// Ports       : clk, rst_n      - clock, async active-low reset
//               push, wr_data   - write strobe and entry (ignored when full)
//               pop             - discard head (ignored when empty)
//               head            - oldest entry (holds last value when empty)
//               count           - occupancy 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module skid_fifo2
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  alu_result_t wr_data,
   output alu_result_t head,
   output logic [1:0]  count
);

   alu_result_t head_q, head_d;
   alu_result_t tail_q, tail_d;
   logic [1:0]  count_q, count_d;
   logic        push_ok;
   logic        pop_ok;

   always_comb begin
      push_ok = push & (count_q != 2'd2);
      pop_ok  = pop  & (count_q != 2'd0);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};

      // Popping a full buffer promotes the tail into the head.
      if (pop_ok && (count_q == 2'd2)) begin
         head_d = tail_q;
      end

      // A new entry lands in the head when the head slot will be free after
      // this edge (empty, or the single entry is leaving); otherwise it
      // queues behind the head in the tail.
      if (push_ok) begin
         if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_ok)) begin
            head_d = wr_data;
         end else begin
            tail_d = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head  = head_q;
   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered output stage behind the 16-bit ALU. Buffers up to
//               two {Z, flags} results behind a valid/ready handshake and
//               keeps a last-flags status register, a ZR consistency pulse,
//               a delivered-result counter and optional sticky CY/V bits.
// Ports       : in_valid/in_ready/in_z/in_flags     - upstream handshake
//               out_valid/out_ready/out_z/out_flags - downstream handshake
//               status     - flags of the most recently accepted result
//               zr_err     - one-cycle pulse after a push whose ZR flag
//                            disagrees with (in_z == 0)
//               result_cnt - number of results popped, wraps
//               sticky_clr/sticky_cy/sticky_v - present only when
//                            ALU_RS_STICKY_EN is defined
// Config      : `define ALU_RS_STICKY_EN to build the sticky CY/V record.
//               DW must equal alu_pkg::ALU_DW (the buffered word is
//               alu_result_t).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DW    = ALU_DW,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_z,
   input  logic [4:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_z,
   output logic [4:0]       out_flags,
   output logic [4:0]       status,
   output logic             zr_err,
`ifdef ALU_RS_STICKY_EN
   input  logic             sticky_clr,
   output logic             sticky_cy,
   output logic             sticky_v,
`endif
   output logic [CNT_W-1:0] result_cnt
);

   alu_result_t      wr_data;
   alu_result_t      head;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   alu_flags_t       status_q, status_d;
   logic             zr_err_q, zr_err_d;
   logic [CNT_W-1:0] result_cnt_q, result_cnt_d;

   // Handshake decodes come only from the registered occupancy, so there is
   // no combinational path from out_ready to in_ready.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign wr_data.z     = in_z;
   assign wr_data.flags = in_flags;

   skid_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_data),
      .head    (head),
      .count   (count)
   );

   assign out_z     = head.z;
   assign out_flags = head.flags;

   always_comb begin
      status_d     = push ? in_flags : status_q;
      zr_err_d     = push & (in_flags[FLAG_ZR] != (in_z == '0));
      result_cnt_d = pop ? (result_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1})
                         : result_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q     <= '0;
         zr_err_q     <= 1'b0;
         result_cnt_q <= '0;
      end else begin
         status_q     <= status_d;
         zr_err_q     <= zr_err_d;
         result_cnt_q <= result_cnt_d;
      end
   end

   assign status     = status_q;
   assign zr_err     = zr_err_q;
   assign result_cnt = result_cnt_q;

`ifdef ALU_RS_STICKY_EN
   logic sticky_cy_q, sticky_cy_d;
   logic sticky_v_q,  sticky_v_d;

   // Set has priority over clear so an event arriving with sticky_clr is
   // still recorded.
   always_comb begin
      sticky_cy_d = (push & in_flags[FLAG_CY]) | (sticky_cy_q & ~sticky_clr);
      sticky_v_d  = (push & in_flags[FLAG_V])  | (sticky_v_q  & ~sticky_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_cy_q <= 1'b0;
         sticky_v_q  <= 1'b0;
      end else begin
         sticky_cy_q <= sticky_cy_d;
         sticky_v_q  <= sticky_v_d;
      end
   end

   assign sticky_cy = sticky_cy_q;
   assign sticky_v  = sticky_v_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage. A reference model
//               (queue of expected results plus status/counter variables)
//               is updated from the observed handshakes; a monitor on the
//               falling edge compares every DUT output against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

   localparam int DW    = 16;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_z;
   logic [4:0]       in_flags;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_z;
   logic [4:0]       out_flags;
   logic [4:0]       status;
   logic             zr_err;
   logic [CNT_W-1:0] result_cnt;
`ifdef ALU_RS_STICKY_EN
   logic             sticky_clr;
   logic             sticky_cy;
   logic             sticky_v;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_z       (in_z),
      .in_flags   (in_flags),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_z      (out_z),
      .out_flags  (out_flags),
      .status     (status),
      .zr_err     (zr_err),
`ifdef ALU_RS_STICKY_EN
      .sticky_clr (sticky_clr),
      .sticky_cy  (sticky_cy),
      .sticky_v   (sticky_v),
`endif
      .result_cnt (result_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [20:0] mq[$];        // expected {z, flags}, oldest first
   logic [4:0]  m_status = '0;
   logic        m_zr     = 1'b0;
   int          m_cnt    = 0;
   logic        m_scy    = 1'b0;
   logic        m_sv     = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_status = '0;
         m_zr     = 1'b0;
         m_cnt    = 0;
         m_scy    = 1'b0;
         m_sv     = 1'b0;
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_in_ready",  32'(in_ready),  32'd1);
         chk("rst_out_data",  32'({out_z, out_flags}), 32'd0);
         chk("rst_status",    32'(status),     32'd0);
         chk("rst_zr_err",    32'(zr_err),     32'd0);
         chk("rst_cnt",       32'(result_cnt), 32'd0);
`ifdef ALU_RS_STICKY_EN
         chk("rst_sticky", 32'({sticky_cy, sticky_v}), 32'd0);
`endif
      end else begin
         logic p;
         logic q;
         chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
         chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
         if (mq.size() > 0)
            chk("out_data", 32'({out_z, out_flags}), 32'(mq[0]));
         chk("status",     32'(status),     32'(m_status));
         chk("zr_err",     32'(zr_err),     32'(m_zr));
         chk("result_cnt", 32'(result_cnt), 32'(m_cnt));
`ifdef ALU_RS_STICKY_EN
         chk("sticky_cy", 32'(sticky_cy), 32'(m_scy));
         chk("sticky_v",  32'(sticky_v),  32'(m_sv));
`endif
         // advance model to the state after the next rising edge
         p = in_valid && (mq.size() < 2);
         q = out_ready && (mq.size() > 0);
         m_zr = p && (in_flags[3] != (in_z == 16'h0000));
         if (q) begin
            void'(mq.pop_front());
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
         end
         if (p) begin
            mq.push_back({in_z, in_flags});
            m_status = in_flags;
         end
`ifdef ALU_RS_STICKY_EN
         m_scy = (p && in_flags[2]) || (m_scy && !sticky_clr);
         m_sv  = (p && in_flags[0]) || (m_sv  && !sticky_clr);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] z, input logic [4:0] f);
      in_valid = v;
      in_z     = z;
      in_flags = f;
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (out_valid && n < 20) begin
         cyc();
         n++;
      end
      chk("drain_timeout", 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 16'h0, 5'h0);
`ifdef ALU_RS_STICKY_EN
      sticky_clr = 1'b0;
`endif
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();

      // single result, CY and V set, consumer ready
      out_ready = 1'b1;
      drive(1'b1, 16'h0FFF, 5'b00101);
      cyc();
      drive(1'b0, 16'h0, 5'h0);
      repeat (3) cyc();

      // fill both entries with consumer stalled, then release in order
      out_ready = 1'b0;
      drive(1'b1, 16'h0000, 5'b01100);
      cyc();
      drive(1'b1, 16'hFFFF, 5'b10000);
      cyc();
      drive(1'b0, 16'h1234, 5'h0);
      cyc();
      chk("full_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      repeat (3) cyc();

      // ZR consistency pulse
      drive(1'b1, 16'h0001, 5'b01000);
      cyc();
      drive(1'b0, 16'h0, 5'h0);
      repeat (2) cyc();
      drive(1'b1, 16'h0000, 5'b01000);
      cyc();
      drive(1'b0, 16'h0, 5'h0);
      repeat (2) cyc();

`ifdef ALU_RS_STICKY_EN
      // set beats clear, then clear alone
      drive(1'b1, 16'h0005, 5'b00001);
      sticky_clr = 1'b1;
      cyc();
      drive(1'b0, 16'h0, 5'h0);
      cyc();
      sticky_clr = 1'b0;
      repeat (2) cyc();
`endif

      // 300 back-to-back results from a fresh counter
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 16'($urandom), 5'($urandom));
         cyc();
      end
      drain();
      chk("cnt_wrap", 32'(result_cnt), 32'd44);

      // randomized traffic, upstream holds data while stalled
      for (int i = 0; i < 600; i++) begin
         if (!(in_valid && !in_ready)) begin
            logic [15:0] z;
            logic [4:0]  f;
            z = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            f = 5'($urandom);
            drive(($urandom_range(0, 2) != 0), z, f);
         end
         out_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_RS_STICKY_EN
         sticky_clr = ($urandom_range(0, 7) == 0);
`endif
         cyc();
      end
`ifdef ALU_RS_STICKY_EN
      sticky_clr = 1'b0;
`endif
      drain();

      // asynchronous reset with two entries buffered
      out_ready = 1'b0;
      drive(1'b1, 16'hAAAA, 5'b00100);
      cyc();
      drive(1'b1, 16'h5555, 5'b00001);
      cyc();
      drive(1'b0, 16'h0, 5'h0);
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_in_ready",  32'(in_ready),  32'd1);
      chk("async_cnt",       32'(result_cnt), 32'd0);
      chk("async_status",    32'(status),     32'd0);
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 16'h00C3, 5'b00010);
      cyc();
      drain();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
